// File: rtl/solver_pkg.sv
// Shared types and defaults for the image-memory arbiter slice.
// Optional read-issue statistics are enabled with IMAGE_MEM_ARB_STATS_EN.
package solver_pkg;

    localparam int N_REQ_DEF   = 40;
    localparam int MEM_LAT_DEF = 2;

    typedef logic        [8:0] coord_t;
    typedef logic signed [8:0] pixel_t;
    typedef logic        [5:0] req_id_t;

    // Tag carried alongside an in-flight read until its data returns
    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    y0;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_IDLE = '0;

    // Each 18-bit memory word holds two 9-bit pixels; odd rows use the low half
    function automatic pixel_t pix_half(input logic [17:0] word, input logic y0);
        pixel_t v;
        if (y0) begin
            v = pixel_t'(word[8:0]);
        end else begin
            v = pixel_t'(word[17:9]);
        end
        return v;
    endfunction

endpackage

// File: rtl/image_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: the search starts one past the
// last-granted index and wraps from N_REQ-1 back to 0.
module rr_picker
    import solver_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] i_req,
    input  req_id_t          i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output req_id_t          o_idx,
    output logic             o_any
);

    int   w_cand;
    logic w_hit;

    // Walk the requesters in priority order and keep the first one found
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = 0;
        w_hit  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = (int'(i_ptr) + k) % N_REQ;
            w_hit  = !o_any && i_req[w_cand];
            o_idx  = w_hit ? req_id_t'(w_cand) : o_idx;
            o_any  = o_any | w_hit;
        end
        for (int i = 0; i < N_REQ; i++) begin
            o_gnt[i] = o_any && (int'(o_idx) == i);
        end
    end

endmodule

// File: rtl/image_mem_arbiter.sv
// Shared image-memory port arbiter: writes take absolute priority, reads
// are granted round-robin and fully pipelined with a MEM_LAT-deep tag pipe.
// Define IMAGE_MEM_ARB_STATS_EN to count read issues on debug_count.
module image_mem_arbiter
    import solver_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_val,
    input  logic [9*N_REQ-1:0]   req_x,
    input  logic [9*N_REQ-1:0]   req_y,
    output logic [N_REQ-1:0]     req_gnt,
    output logic                 rsp_val,
    output logic [5:0]           rsp_id,
    output logic signed [8:0]    rsp_data,
    input  logic                 wr_val,
    output logic                 wr_ack,
    input  logic [9:0]           wr_addr,
    input  logic [9:0]           wr_mem,
    input  logic [19:0]          wr_data,
    output logic [9:0]           image_mem_addr,
    output logic [9:0]           which_mem,
    output logic                 we,
    output logic [19:0]          image_mem_writeout,
    input  logic [19:0]          image_mem_data,
    output logic                 busy,
    output logic [31:0]          debug_count
);

    logic [N_REQ-1:0] w_pick_gnt;
    req_id_t          w_pick_idx;
    logic             w_pick_any;
    logic             w_rd_issue;
    coord_t           w_sel_x;
    coord_t           w_sel_y;
    logic             w_unused_bits;

    logic [N_REQ-1:0] r_gnt;
    logic             r_we;
    logic             r_wr_ack;
    logic [9:0]       r_addr;
    logic [9:0]       r_mem;
    logic [19:0]      r_wdata;
    req_id_t          r_last;
    rd_tag_t          r_iss;
    rd_tag_t          r_pipe [MEM_LAT];

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .i_req (req_val),
        .i_ptr (r_last),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_rd_issue    = !wr_val && w_pick_any;
    assign w_unused_bits = ^image_mem_data[19:18];

    // Extract the winning requester's coordinates with a one-hot AND-OR mux
    always_comb begin
        w_sel_x = '0;
        w_sel_y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sel_x = w_sel_x | (req_x[9*i +: 9] & {9{w_pick_gnt[i]}});
            w_sel_y = w_sel_y | (req_y[9*i +: 9] & {9{w_pick_gnt[i]}});
        end
    end

    // Issue at most one memory operation per cycle: write first, else one read
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gnt    <= '0;
            r_we     <= 1'b0;
            r_wr_ack <= 1'b0;
            r_addr   <= 10'd0;
            r_mem    <= 10'd0;
            r_wdata  <= 20'd0;
            r_last   <= req_id_t'(N_REQ - 1);
            r_iss    <= RD_TAG_IDLE;
        end else if (wr_val) begin
            r_gnt    <= '0;
            r_we     <= 1'b1;
            r_wr_ack <= 1'b1;
            r_addr   <= wr_addr;
            r_mem    <= wr_mem;
            r_wdata  <= wr_data;
            r_iss    <= RD_TAG_IDLE;
        end else if (w_rd_issue) begin
            r_gnt    <= w_pick_gnt;
            r_we     <= 1'b0;
            r_wr_ack <= 1'b0;
            r_addr   <= {1'b0, w_sel_x};
            r_mem    <= {2'b00, w_sel_y[8:1]};
            r_last   <= w_pick_idx;
            r_iss    <= {1'b1, w_pick_idx, w_sel_y[0]};
        end else begin
            r_gnt    <= '0;
            r_we     <= 1'b0;
            r_wr_ack <= 1'b0;
            r_iss    <= RD_TAG_IDLE;
        end
    end

    // Shift read tags so the last stage lines up with the returning memory data
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                r_pipe[i] <= RD_TAG_IDLE;
            end
        end else begin
            r_pipe[0] <= r_iss;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Busy while any tag is still travelling down the pipe
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            busy = busy | r_pipe[i].valid;
        end
    end

    assign req_gnt            = r_gnt;
    assign we                 = r_we;
    assign wr_ack             = r_wr_ack;
    assign image_mem_addr     = r_addr;
    assign which_mem          = r_mem;
    assign image_mem_writeout = r_wdata;
    assign rsp_val            = r_pipe[MEM_LAT-1].valid;
    assign rsp_id             = r_pipe[MEM_LAT-1].id;
    assign rsp_data           = rsp_val ? pix_half(image_mem_data[17:0], r_pipe[MEM_LAT-1].y0)
                                        : 9'sd0;

`ifdef IMAGE_MEM_ARB_STATS_EN
    logic [31:0] r_dbg_cnt;

    // Count read issues, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dbg_cnt <= 32'd0;
        end else if (w_rd_issue && (r_dbg_cnt != 32'hFFFF_FFFF)) begin
            r_dbg_cnt <= r_dbg_cnt + 32'd1;
        end else begin
            r_dbg_cnt <= r_dbg_cnt;
        end
    end

    assign debug_count = r_dbg_cnt;
`else
    assign debug_count = 32'd0;
`endif

endmodule
